// File: rtl/demux_router.sv
// demux_router: routes one upstream word per cycle into one of NCH registered output slots.
// Optional transfer counter is compiled in with DEMUX_ROUTER_CNT_EN.
module demux_router #(
  parameter int unsigned DW   = 8,
  parameter int unsigned NCH  = 4,
  parameter int unsigned SELW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_data,
  input  logic [SELW-1:0]   in_sel,
  output logic              in_ready,
  output logic [NCH-1:0]    out_valid,
  output logic [NCH*DW-1:0] out_data,
  input  logic [NCH-1:0]    out_ready,
  output logic              sel_err,
  output logic [15:0]       xfer_cnt
);

  // One extra bit so NCH == 2**SELW is representable.
  localparam logic [SELW:0] NchLim = (SELW + 1)'(NCH);

  logic [NCH-1:0]         valid_q, valid_d;
  logic [NCH-1:0][DW-1:0] data_q, data_d;
  logic                   sel_err_q, sel_err_d;
  logic [NCH-1:0]         load_vec;
  logic                   sel_legal;
  logic                   slot_free;
  logic                   accept;

  assign sel_legal = ({1'b0, in_sel} < NchLim);

  always_comb begin
    slot_free = 1'b0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (in_sel == SELW'(k)) begin
        slot_free = !valid_q[k] || out_ready[k];
      end
    end
  end

  // Illegal selects are always accepted so they can be dropped without stalling.
  assign in_ready = rst_n && (!sel_legal || slot_free);
  assign accept   = in_valid && in_ready;

  always_comb begin
    load_vec = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      load_vec[k] = accept && sel_legal && (in_sel == SELW'(k));
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (load_vec[k]) begin
        valid_d[k] = 1'b1;
        data_d[k]  = in_data;
      end else if (valid_q[k] && out_ready[k]) begin
        valid_d[k] = 1'b0;
      end
    end
    sel_err_d = accept && !sel_legal;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= '0;
      data_q    <= '0;
      sel_err_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign sel_err   = sel_err_q;

`ifdef DEMUX_ROUTER_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (accept && sel_legal && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 16'h0000;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign xfer_cnt = cnt_q;
`else
  assign xfer_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_demux_router.sv
// Directed self-checking bench for demux_router: a 4-channel instance and a 3-channel
// instance (for illegal selects). Counter expectations follow DEMUX_ROUTER_CNT_EN.
module tb_demux_router;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic [1:0]  in_sel = '0;
  logic        in_ready;
  logic [3:0]  out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_ready = '0;
  logic        sel_err;
  logic [15:0] xfer_cnt;

  logic        in_valid3 = 1'b0;
  logic [7:0]  in_data3 = '0;
  logic [1:0]  in_sel3 = '0;
  logic        in_ready3;
  logic [2:0]  out_valid3;
  logic [23:0] out_data3;
  logic [2:0]  out_ready3 = '0;
  logic        sel_err3;
  logic [15:0] xfer_cnt3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  demux_router #(.DW(8), .NCH(4), .SELW(2)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sel_err   (sel_err),
    .xfer_cnt  (xfer_cnt)
  );

  demux_router #(.DW(8), .NCH(3), .SELW(2)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid3),
    .in_data   (in_data3),
    .in_sel    (in_sel3),
    .in_ready  (in_ready3),
    .out_valid (out_valid3),
    .out_data  (out_data3),
    .out_ready (out_ready3),
    .sel_err   (sel_err3),
    .xfer_cnt  (xfer_cnt3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int n);
`ifdef DEMUX_ROUTER_CNT_EN
    return (n > 65535) ? 32'h0000_FFFF : 32'(n);
`else
    return 32'h0;
`endif
  endfunction

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Initial reset, then fill all four slots.
    tick();
    tick();
    rst_n = 1'b1;
    out_ready = 4'b0000;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_sel  = 2'(i);
      in_data = 8'(8'h10 + i);
      tick();
    end
    in_valid = 1'b0;
    check_eq("fill_valid", 32'(out_valid), 32'h0000_000F);
    check_eq("fill_data", out_data, 32'h1312_1110);

    // Mid-stream reset with a word presented and all consumers ready.
    rst_n = 1'b0;
    out_ready = 4'b1111;
    in_valid = 1'b1;
    in_sel = 2'd0;
    in_data = 8'h77;
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'h0);
    tick();
    tick();
    check_eq("rst_valid", 32'(out_valid), 32'h0);
    check_eq("rst_data", out_data, 32'h0);
    check_eq("rst_sel_err", 32'(sel_err), 32'h0);
    check_eq("rst_cnt", 32'(xfer_cnt), 32'h0);
    check_eq("rst_in_ready2", 32'(in_ready), 32'h0);

    // First accept on the first edge after release.
    rst_n = 1'b1;
    out_ready = 4'b0000;
    tick();
    in_valid = 1'b0;
    check_eq("post_rst_valid", 32'(out_valid), 32'h1);
    check_eq("post_rst_data", 32'(out_data[7:0]), 32'h77);
    check_eq("post_rst_cnt", 32'(xfer_cnt), cnt_exp(1));

    // Drain slot 0; in_valid=0 must not load anything.
    out_ready = 4'b1111;
    in_sel = 2'd1;
    in_data = 8'hFF;
    tick();
    check_eq("drain_valid", 32'(out_valid), 32'h0);
    check_eq("idle_data", out_data, 32'h0000_0077);

    // Routing to channel 2 with consumers stalled.
    out_ready = 4'b0000;
    in_valid = 1'b1;
    in_sel = 2'd2;
    in_data = 8'hA5;
    #1;
    check_eq("route_ready", 32'(in_ready), 32'h1);
    tick();
    check_eq("route_valid", 32'(out_valid), 32'h4);
    check_eq("route_data", 32'(out_data[23:16]), 32'hA5);
    in_data = 8'h5A;
    #1;
    check_eq("full_ready", 32'(in_ready), 32'h0);
    tick();
    check_eq("hold_valid", 32'(out_valid), 32'h4);
    check_eq("hold_data", 32'(out_data[23:16]), 32'hA5);

    // Another channel still accepts while channel 2 is blocked.
    in_sel = 2'd0;
    in_data = 8'h3C;
    #1;
    check_eq("other_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    check_eq("other_valid", 32'(out_valid), 32'h5);
    check_eq("other_data", out_data, 32'h00A5_003C);
    check_eq("other_cnt", 32'(xfer_cnt), cnt_exp(3));

    // Drain only channel 2; its data stays at the last value.
    out_ready = 4'b0100;
    tick();
    check_eq("drain2_valid", 32'(out_valid), 32'h1);
    check_eq("drain2_data", out_data, 32'h00A5_003C);
    out_ready = 4'b1111;
    tick();
    check_eq("drain_all", 32'(out_valid), 32'h0);

    // Full throughput on channel 1.
    out_ready = 4'b0010;
    in_valid = 1'b1;
    in_sel = 2'd1;
    for (int i = 1; i <= 8; i++) begin
      in_data = 8'(i);
      #1;
      check_eq("tput_ready", 32'(in_ready), 32'h1);
      tick();
      check_eq("tput_valid", 32'(out_valid), 32'h2);
      check_eq("tput_data", 32'(out_data[15:8]), 32'(i));
    end
    in_valid = 1'b0;
    tick();
    check_eq("tput_empty", 32'(out_valid), 32'h0);
    check_eq("tput_cnt", 32'(xfer_cnt), cnt_exp(11));

    // Illegal select on the 3-channel instance.
    in_valid3 = 1'b1;
    in_sel3 = 2'd0;
    in_data3 = 8'h21;
    tick();
    check_eq("ch3_valid", 32'(out_valid3), 32'h1);
    in_sel3 = 2'd3;
    in_data3 = 8'h55;
    #1;
    check_eq("ill_ready", 32'(in_ready3), 32'h1);
    check_eq("ill_pre_err", 32'(sel_err3), 32'h0);
    tick();
    in_valid3 = 1'b0;
    check_eq("ill_err", 32'(sel_err3), 32'h1);
    check_eq("ill_valid", 32'(out_valid3), 32'h1);
    check_eq("ill_data", 32'(out_data3), 32'h0000_0021);
    check_eq("ill_cnt", 32'(xfer_cnt3), cnt_exp(1));
    tick();
    check_eq("ill_err_pulse", 32'(sel_err3), 32'h0);
    check_eq("dut4_no_err", 32'(sel_err), 32'h0);

`ifdef DEMUX_ROUTER_CNT_EN
    // Saturation: 70000 further accepts on channel 3.
    out_ready = 4'b1111;
    in_valid = 1'b1;
    in_sel = 2'd3;
    for (int i = 0; i < 70000; i++) begin
      in_data = 8'(i);
      tick();
    end
    in_valid = 1'b0;
    check_eq("cnt_sat", 32'(xfer_cnt), 32'h0000_FFFF);
`else
    check_eq("cnt_off", 32'(xfer_cnt), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/demux_router.md
DEMUX_ROUTER -- requirements
Module: demux_router

Interface
REQ-001 SHALL have parameter DW, default 8, data width in bits (>=1).
REQ-002 SHALL have parameter NCH, default 4, output channel count (2..2**SELW).
REQ-003 SHALL have parameter SELW, default 2, select width in bits (>=1).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  upstream word present.
REQ-007 SHALL have port in_data  input  DW  upstream word.
REQ-008 SHALL have port in_sel  input  SELW  destination channel index.
REQ-009 SHALL have port in_ready  output  1  upstream word accepted when in_valid&in_ready.
REQ-010 SHALL have port out_valid  output  NCH  per-channel word present; bit k = channel k.
REQ-011 SHALL have port out_data  output  NCH*DW  channel k data at bits [k*DW +: DW].
REQ-012 SHALL have port out_ready  input  NCH  per-channel downstream accept.
REQ-013 SHALL have port sel_err  output  1  one-cycle pulse: word with illegal select dropped.
REQ-014 SHALL have port xfer_cnt  output  16  count of accepted legal words (see Configuration).

Function
REQ-015 SHALL hold one registered slot per channel (valid bit + DW data).
REQ-016 SHALL drive in_ready = 1 when in_sel >= NCH, else (!out_valid[in_sel] | out_ready[in_sel]); in_ready SHALL be 0 while rst_n = 0.
REQ-017 SHALL, on accept with legal in_sel, load in_data into slot in_sel and set out_valid[in_sel] on the next edge (latency 1 cycle).
REQ-018 SHALL clear out_valid[k] after an edge with out_valid[k]&out_ready[k] and no load into slot k.
REQ-019 SHALL, on simultaneous drain and load of slot k, keep out_valid[k] = 1 with the new data (full throughput, one word/cycle/channel).
REQ-020 SHALL hold out_data slot k stable while out_valid[k]=1 and out_ready[k]=0.
REQ-021 SHALL leave every channel other than in_sel unchanged except for its own drain.
REQ-022 SHALL, on accept with in_sel >= NCH, discard the word, modify no slot, and assert sel_err for exactly the following cycle.
REQ-023 SHALL leave out_data of an empty slot at its last value; consumers SHALL qualify with out_valid.
REQ-024 SHALL ignore in_data/in_sel when in_valid = 0.

Reset
REQ-025 SHALL, on any edge with rst_n = 0, clear all out_valid bits, all out_data to 0, sel_err to 0, xfer_cnt to 0.
REQ-026 SHALL discard any word presented or held during reset (reset mid-stream loses in-flight slots); first accept possible on the first edge after rst_n returns to 1.

Configuration
REQ-027 SHALL use macro DEMUX_ROUTER_CNT_EN to compile the transfer counter in or out.
REQ-028 SHALL, with DEMUX_ROUTER_CNT_EN defined, increment xfer_cnt by 1 per accepted legal word, saturating at 16'hFFFF; illegal-select words SHALL not count.
REQ-029 SHALL, without DEMUX_ROUTER_CNT_EN, tie xfer_cnt to 16'h0000 and contain no counter flops; all other behaviour identical.

Verification
REQ-030 Reset: rst_n=0 two edges with out_valid previously 4'b1111 -> out_valid=0, out_data=0, sel_err=0, xfer_cnt=0, in_ready=0 during reset.
REQ-031 Routing: in_sel=2, in_data=8'hA5, all out_ready=0 -> next cycle out_valid=4'b0100, out_data[23:16]=8'hA5; second word to sel 2 -> in_ready=0, slot holds 8'hA5.
REQ-032 Throughput: out_ready[1]=1, words 8'h01..8'h08 on consecutive cycles to sel 1 -> in_ready stays 1, out_data[15:8] shows 01..08 one per cycle, no loss or duplication.
REQ-033 Illegal select: NCH=3, SELW=2, in_sel=3, in_data=8'h55 -> in_ready=1, sel_err=1 for one cycle, out_valid unchanged, xfer_cnt unchanged.
REQ-034 Counter: with DEMUX_ROUTER_CNT_EN, 70000 legal accepts -> xfer_cnt=16'hFFFF; without macro -> xfer_cnt=0 throughout.
